// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : FIFO-buffered UART transmitter (LSB-first, optional parity,
//               1/2 stop bits, programmable baud divisor)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_fifo_wr,
    input  logic [7:0]  tx_fifo_data_in,
    input  logic [14:0] uart_control,
    output logic        tx,
    output logic        tx_full,
    output logic        tx_empty,
    output logic        tx_busy,
    output logic        tx_overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  shift_q, shift_d;
    logic [10:0] div_q, div_d;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic        par_en_q, par_en_d;
    logic        par_bit_q, par_bit_d;
    logic        two_stop_q, two_stop_d;
    logic        stop2_q, stop2_d;
    logic        ovf_q, ovf_d;

    logic        w_push;
    logic        w_pop;
    logic        w_bit_end;
    logic [10:0] w_cnt_next;
    logic [7:0]  w_head;

    assign tx_empty    = (wr_ptr_q == rd_ptr_q);
    assign tx_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tx_busy     = (state_q != S_IDLE);
    assign tx_overflow = ovf_q;

    // Full is judged before any same-cycle pop, so a push into a full FIFO is always lost.
    assign w_push     = tx_fifo_wr && !tx_full;
    assign w_pop      = (state_q == S_IDLE) && uart_control[0] && !tx_empty;
    assign w_head     = mem_q[rd_ptr_q[AW-1:0]];
    assign w_bit_end  = (cnt_q == 11'd0);
    assign w_cnt_next = w_bit_end ? div_q : (cnt_q - 11'd1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_fifo_data_in;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (AW+1)'(w_push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(w_pop);
        ovf_d      = ovf_q | (tx_fifo_wr & tx_full);
        state_d    = state_q;
        shift_d    = shift_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;

        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    shift_d    = w_head;
                    div_d      = uart_control[14:4];
                    cnt_d      = uart_control[14:4];
                    par_en_d   = uart_control[2];
                    par_bit_d  = (^w_head) ^ uart_control[3];
                    two_stop_d = uart_control[1];
                    state_d    = S_START;
                end
            end
            S_START: begin
                cnt_d = w_cnt_next;
                if (w_bit_end) begin
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = w_cnt_next;
                if (w_bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        stop2_d = 1'b0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                cnt_d = w_cnt_next;
                if (w_bit_end) begin
                    stop2_d = 1'b0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                cnt_d = w_cnt_next;
                if (w_bit_end) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level is decoded from the state register, so reset drives it high at once.
    always_comb begin
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
            S_PARITY: tx = par_bit_q;
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            shift_q    <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit half of the UART peripheral. It sits on the far side of the load/store unit's TX path. It buffers bytes pushed by the LSU's TX-FIFO write strobe in an internal FIFO and serializes them LSB-first onto the `tx` line, using the frame format and baud divisor from the LSU control register. It also returns FIFO/busy status bits for the LSU's status word.

## Interface
Parameters:
- `DEPTH`, default 8: TX FIFO depth in bytes; power of two, ≥2.

Ports:
- `clk`, input, 1: system clock, rising-edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `tx_fifo_wr`, input, 1: push strobe from LSU; one byte per asserted cycle.
- `tx_fifo_data_in`, input, 8: byte to push.
- `uart_control`, input, 15: [0] tx_en; [1] two stop bits; [2] parity enable; [3] odd parity (0 = even); [14:4] baud divisor D (11 bit).
- `tx`, output, 1: serial line, idle high.
- `tx_full`, output, 1: FIFO holds DEPTH bytes.
- `tx_empty`, output, 1: FIFO holds 0 bytes.
- `tx_busy`, output, 1: FSM not in IDLE.
- `tx_overflow`, output, 1: sticky; set when a push is dropped.

## Operation
- FIFO: circular buffer with read/write pointers of log2(DEPTH)+1 bits.
  - Full when the pointers differ only in their MSB; empty when they are equal.
  - A push while `tx_full` is dropped and sets `tx_overflow`. This applies even if a pop occurs in the same cycle, because full is evaluated before the pop.
  - A push and a pop in the same cycle on a non-full, non-empty FIFO both take effect.
  - `tx_overflow` clears only on reset.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - **IDLE**: `tx`=1. If `tx_en` and `!tx_empty`, then on that edge:
    - pop the FIFO head into the shift register;
    - latch D, parity enable, parity odd, and stop count;
    - go to START.
  - **START**: `tx`=0 for one bit time, then go to DATA with bit index 0.
  - **DATA**: `tx`=shift[0] for one bit time per bit; shift right after each bit.
    - After bit 7, go to PARITY if parity is enabled, else STOP.
  - **PARITY**: `tx` = XOR of the 8 data bits, XOR odd flag. One bit time, then STOP.
  - **STOP**: `tx`=1 for one bit time, or two if two stop bits are selected. Then go to IDLE.
- Bit time is D+1 clocks (D=0 gives 1 clock per bit).
  - A baud counter loads D on every state or bit change and decrements to 0.
  - The bit ends on the cycle the counter equals 0.
- Frame length is (D+1)×(10 + parity + extra stop) clocks.
- Control fields are latched at frame start. Changes mid-frame, including dropping `tx_en`, affect only the next frame; the current frame always completes.
- With `tx_en`=0, pushes still queue normally; nothing is transmitted.
- Back-to-back: from STOP, the FSM always passes through IDLE for exactly 1 clock, so there is one extra idle-high clock between frames.

## Timing
- Reset (asynchronous, `rst_n`=0): FSM goes to IDLE and both pointers go to 0.
  - Outputs: `tx`=1, `tx_empty`=1, `tx_full`=0, `tx_busy`=0, `tx_overflow`=0.
  - FIFO contents are don't-care.
  - Reset mid-frame aborts the frame immediately, with `tx` forced high asynchronously.
- All outputs are registered or decoded from registers; no combinational path from inputs to outputs.
- Push latency:
  - Push sampled at edge k: `tx_empty` falls after edge k.
  - If idle and enabled, the pop occurs at edge k+1, and `tx` falls and `tx_busy` rises after edge k+1.
- Pop frees space at the same edge: `tx_full` falls after the pop edge.

## Test plan
- Reset then idle: assert `rst_n`=0 mid-sim → `tx`=1, `tx_empty`=1, `tx_busy`=0, `tx_overflow`=0.
- 8N1 single byte: control D=3, tx_en=1; push 0x55 → 40-clock frame, with each level held 4 clocks: 0, then 1,0,1,0,1,0,1,0, then 1. `tx_busy` drops after 40 clocks; `tx_empty`=1.
- Even parity, 2 stop bits: control D=0, parity enable=1, odd=0, two stop=1; push 0x07 → 12 clocks: 0, then 1,1,1,0,0,0,0,0, then parity 1, then 1,1.
- Overflow: tx_en=0, DEPTH=8; push 0x00..0x08 (9 pushes) → `tx_full`=1 after the 8th push, 9th dropped, `tx_overflow`=1. Then set tx_en=1 → bytes 0x00..0x07 sent in order; 0x08 never sent.
- Back-to-back / mid-frame control change: push 0xA5, 0x3C with D=1. During the first frame, change D to 5 and clear tx_en → 0xA5 completes at 2 clocks/bit, 0x3C is not started. Set tx_en=1 → 0x3C sent at 6 clocks/bit.
- Reset mid-frame: push 0xFF, assert `rst_n` low during DATA → `tx`=1 immediately, FIFO empty. No residual frame after release.
